assert_fail_sequencer: RTL

ASSERT_FAIL_SEQUENCER -- requirements
Module: assert_fail_sequencer

---
 rtl/assert_fail_sequencer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/assert_fail_sequencer.sv
// Collects assertion-monitor failures from NREQ sources, reports them one at a time
// round-robin, keeps sticky flags and a saturating count, and raises a delayed fatal stop.
module assert_fail_sequencer #(
    parameter int NREQ       = 4,
    parameter int ID_W       = 8,
    parameter int CNT_W      = 16,
    parameter int STOP_DELAY = 8
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic                     enable_i,
    input  logic [NREQ-1:0]          fail_valid_i,
    input  logic [NREQ*ID_W-1:0]     fail_id_i,
    input  logic                     clear_i,
    input  logic                     report_ready_i,
    output logic                     report_valid_o,
    output logic [$clog2(NREQ)-1:0]  report_src_o,
    output logic [ID_W-1:0]          report_id_o,
    output logic [NREQ-1:0]          sticky_o,
    output logic [CNT_W-1:0]         fail_count_o,
    output logic                     stop_o
);

    localparam int SRC_W = $clog2(NREQ);
    localparam int SUM_W = CNT_W + 5;
    localparam logic [7:0] DELAY_INIT = 8'(STOP_DELAY - 1);
    localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_ARMED = 2'd1,
        ST_HALT  = 2'd2
    } stop_state_e;

    function automatic logic [SUM_W-1:0] popcount(input logic [NREQ-1:0] v);
        logic [SUM_W-1:0] n;
        n = '0;
        for (int i = 0; i < NREQ; i++) begin
            n = n + SUM_W'(v[i]);
        end
        return n;
    endfunction

    logic [NREQ-1:0]  accept_s;
    logic             load_s;
    logic             grant_found_s;
    logic [SRC_W-1:0] grant_idx_s;
    logic [SUM_W-1:0] sum_s;

    logic [NREQ-1:0]  pend_q, pend_d;
    logic [ID_W-1:0]  pid_q [NREQ];
    logic [ID_W-1:0]  pid_d [NREQ];
    logic             rv_q, rv_d;
    logic [SRC_W-1:0] src_q, src_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [SRC_W-1:0] last_q, last_d;
    logic [NREQ-1:0]  sticky_q, sticky_d;
    logic [CNT_W-1:0] count_q, count_d;
    stop_state_e      state_q, state_d;
    logic [7:0]       dly_q, dly_d;
    logic             stop_q, stop_d;

    assign accept_s = fail_valid_i & {NREQ{enable_i}};
    assign load_s   = !rv_q || report_ready_i;
    assign sum_s    = SUM_W'(count_q) + popcount(accept_s);

    // Round-robin pick: first pending source after the last granted one.
    always_comb begin
        logic             hit;
        logic [SRC_W-1:0] cand;
        grant_found_s = 1'b0;
        grant_idx_s   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand          = SRC_W'((int'(last_q) + k) % NREQ);
            hit           = pend_q[cand] & ~grant_found_s;
            grant_idx_s   = hit ? cand : grant_idx_s;
            grant_found_s = grant_found_s | hit;
        end
    end

    // Pending slots, output register, sticky flags and failure counter.
    always_comb begin
        pend_d = pend_q;
        pid_d  = pid_q;
        rv_d   = rv_q;
        src_d  = src_q;
        id_d   = id_q;
        last_d = last_q;
        if (load_s) begin
            rv_d = grant_found_s;
            if (grant_found_s) begin
                src_d               = grant_idx_s;
                id_d                = pid_q[grant_idx_s];
                last_d              = grant_idx_s;
                pend_d[grant_idx_s] = 1'b0;
            end else begin
                src_d = src_q;
            end
        end else begin
            rv_d = rv_q;
        end
        // A new failure re-arms its slot even on the edge it is granted.
        for (int i = 0; i < NREQ; i++) begin
            if (accept_s[i]) begin
                pend_d[i] = 1'b1;
                pid_d[i]  = fail_id_i[i*ID_W +: ID_W];
            end else begin
                pid_d[i] = pid_d[i];
            end
        end
        if (clear_i) begin
            sticky_d = '0;
            count_d  = '0;
        end else begin
            sticky_d = sticky_q | accept_s;
            count_d  = (sum_s > CNT_MAX) ? CNT_MAX[CNT_W-1:0] : sum_s[CNT_W-1:0];
        end
    end

    // Stop sequencing: arm on first failure, count down, then halt until reset.
    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        case (state_q)
            ST_RUN: begin
                if (|accept_s) begin
                    state_d = ST_ARMED;
                    dly_d   = DELAY_INIT;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_ARMED: begin
                if (dly_q == 8'd0) begin
                    state_d = ST_HALT;
                end else begin
                    dly_d = dly_q - 8'd1;
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RUN;
        endcase
        stop_d = (state_d == ST_HALT);
    end

    // State registers with synchronous reset.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            pend_q   <= '0;
            for (int i = 0; i < NREQ; i++) begin
                pid_q[i] <= '0;
            end
            rv_q     <= 1'b0;
            src_q    <= '0;
            id_q     <= '0;
            last_q   <= SRC_W'(NREQ - 1);
            sticky_q <= '0;
            count_q  <= '0;
            state_q  <= ST_RUN;
            dly_q    <= 8'd0;
            stop_q   <= 1'b0;
        end else begin
            pend_q   <= pend_d;
            pid_q    <= pid_d;
            rv_q     <= rv_d;
            src_q    <= src_d;
            id_q     <= id_d;
            last_q   <= last_d;
            sticky_q <= sticky_d;
            count_q  <= count_d;
            state_q  <= state_d;
            dly_q    <= dly_d;
            stop_q   <= stop_d;
        end
    end

    assign report_valid_o = rv_q;
    assign report_src_o   = src_q;
    assign report_id_o    = id_q;
    assign sticky_o       = sticky_q;
    assign fail_count_o   = count_q;
    assign stop_o         = stop_q;

endmodule
